// File: rtl/reg_file_mp_pkg.sv
// Shared types and helpers for the multi-read-port register file.
// be_merge works on a wide word; callers zero-extend in and truncate out.
package regfile_pkg;

    typedef enum logic {IDLE = 1'b0, SWEEP = 1'b1} state_t;

    localparam int MAX_SIZE = 1024;

    function automatic bit size_ok(input int size);
        return (size > 0) && (size % 8 == 0) && (size <= MAX_SIZE);
    endfunction

    function automatic logic [MAX_SIZE-1:0] be_merge(
        input logic [MAX_SIZE-1:0]   old_w,
        input logic [MAX_SIZE-1:0]   new_w,
        input logic [MAX_SIZE/8-1:0] be
    );
        logic [MAX_SIZE-1:0] r;
        r = old_w;
        for (int k = 0; k < MAX_SIZE/8; k++) begin
            if (be[k]) r[8*k +: 8] = new_w[8*k +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/reg_file_mp_if.sv
// Bus bundle for reg_file_mp: write port, read ports, debug tap, clear request.
interface reg_file_mp_if #(
    parameter int ADDR  = 5,
    parameter int SIZE  = 32,
    parameter int NREAD = 2
);
    logic                    Clr_Req;
    logic                    Write_Reg;
    logic [ADDR-1:0]         W_Addr;
    logic [SIZE-1:0]         W_Data;
    logic [SIZE/8-1:0]       W_Be;
    logic [NREAD*ADDR-1:0]   R_Addr;
    logic [NREAD*SIZE-1:0]   R_Data;
    logic [ADDR-1:0]         Dbg_Addr;
    logic [SIZE-1:0]         Dbg_Data;
    logic                    Busy;

    modport master (
        output Clr_Req, Write_Reg, W_Addr, W_Data, W_Be, R_Addr, Dbg_Addr,
        input  R_Data, Dbg_Data, Busy
    );

    modport slave (
        input  Clr_Req, Write_Reg, W_Addr, W_Data, W_Be, R_Addr, Dbg_Addr,
        output R_Data, Dbg_Data, Busy
    );
endinterface

// File: rtl/reg_file_mp_rd_port.sv
// One combinational read port: array read, write-through bypass, r0 and busy masking.
module regfile_rd_port #(
    parameter int ADDR    = 5,
    parameter int SIZE    = 32,
    parameter int NUMB    = 1 << ADDR,
    parameter int BYPASS  = 1,
    parameter int ZERO_R0 = 1
) (
    input  logic [NUMB-1:0][SIZE-1:0] mem,
    input  logic [ADDR-1:0]           r_addr,
    input  logic                      busy,
    input  logic                      wr_fire,
    input  logic [ADDR-1:0]           w_addr,
    input  logic [SIZE-1:0]           wr_merged,
    output logic [SIZE-1:0]           r_data
);
    always_comb begin
        r_data = mem[r_addr];
        if (BYPASS != 0 && wr_fire && r_addr == w_addr) r_data = wr_merged;
        // Zero register and sweep masking win over bypass.
        if ((ZERO_R0 != 0 && r_addr == '0) || busy) r_data = '0;
    end
endmodule

// File: rtl/reg_file_mp.sv
// Multi-read-port register file with byte-enable writes and a one-entry-per-cycle
// clear sweep that runs after reset or on request.
module reg_file_mp
    import regfile_pkg::*;
#(
    parameter int ADDR    = 5,
    parameter int SIZE    = 32,
    parameter int NREAD   = 2,
    parameter int BYPASS  = 1,
    parameter int ZERO_R0 = 1
) (
    input  logic          Clk,
    input  logic          Clr_n,
    reg_file_mp_if.slave  bus
);
    localparam int NUMB = 1 << ADDR;

    if (!size_ok(SIZE)) begin : g_size_chk
        $error("reg_file_mp: SIZE must be a positive multiple of 8");
    end
    if (NREAD < 1 || NREAD > 4) begin : g_nread_chk
        $error("reg_file_mp: NREAD must be in 1..4");
    end

    state_t                    state, state_nx;
    logic [ADDR-1:0]           cnt, cnt_nx;
    logic [NUMB-1:0][SIZE-1:0] mem;
    logic                      busy, swp_fire, wr_fire;
    logic [SIZE-1:0]           wr_old, wr_merged;
    logic [NREAD-1:0][ADDR-1:0] rd_addr;
    logic [NREAD-1:0][SIZE-1:0] rd_data;

    assign busy     = !Clr_n || state == SWEEP;
    assign bus.Busy = busy;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        swp_fire = 1'b0;
        wr_fire  = 1'b0;
        if (bus.Clr_Req) begin
            // Starting or restarting a sweep drops any concurrent write.
            state_nx = SWEEP;
            cnt_nx   = '0;
        end else if (state == SWEEP) begin
            swp_fire = 1'b1;
            cnt_nx   = cnt + 1'b1;
            if (&cnt) state_nx = IDLE;
        end else begin
            wr_fire = Clr_n && bus.Write_Reg && !(ZERO_R0 != 0 && bus.W_Addr == '0);
        end
    end

    always_ff @(posedge Clk) begin
        if (!Clr_n) begin
            state <= SWEEP;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    assign wr_old    = mem[bus.W_Addr];
    assign wr_merged = SIZE'(be_merge(MAX_SIZE'(wr_old), MAX_SIZE'(bus.W_Data),
                                      (MAX_SIZE/8)'(bus.W_Be)));

    // Contents are only ever cleared by the sweep, never by reset directly.
    always_ff @(posedge Clk) begin
        if (Clr_n) begin
            if (swp_fire)     mem[cnt]        <= '0;
            else if (wr_fire) mem[bus.W_Addr] <= wr_merged;
        end
    end

    assign rd_addr    = bus.R_Addr;
    assign bus.R_Data = rd_data;

    for (genvar p = 0; p < NREAD; p++) begin : g_rd
        regfile_rd_port #(
            .ADDR    (ADDR),
            .SIZE    (SIZE),
            .NUMB    (NUMB),
            .BYPASS  (BYPASS),
            .ZERO_R0 (ZERO_R0)
        ) u_rd (
            .mem       (mem),
            .r_addr    (rd_addr[p]),
            .busy      (busy),
            .wr_fire   (wr_fire),
            .w_addr    (bus.W_Addr),
            .wr_merged (wr_merged),
            .r_data    (rd_data[p])
        );
    end

    always_comb begin
        bus.Dbg_Data = mem[bus.Dbg_Addr];
        if (busy || (ZERO_R0 != 0 && bus.Dbg_Addr == '0)) bus.Dbg_Data = '0;
    end
endmodule

// File: tb/tb_reg_file_mp.sv
// Randomised bench for reg_file_mp against an array-based model, plus directed
// sweep-length and literal-value checks.
module tb_reg_file_mp;
    localparam int ADDR  = 5;
    localparam int SIZE  = 32;
    localparam int NREAD = 2;
    localparam int NUMB  = 32;

    logic clk   = 1'b0;
    logic clr_n = 1'b0;
    always #5 clk = ~clk;

    reg_file_mp_if #(.ADDR(ADDR), .SIZE(SIZE), .NREAD(NREAD)) bus();

    reg_file_mp #(
        .ADDR(ADDR), .SIZE(SIZE), .NREAD(NREAD), .BYPASS(1), .ZERO_R0(1)
    ) dut (
        .Clk   (clk),
        .Clr_n (clr_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [31:0] mdl [NUMB];
    int          sweep_left = NUMB;

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] be);
        logic [31:0] mask;
        mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return (o & ~mask) | (n & mask);
    endfunction

    function automatic bit m_busy();
        return !clr_n || sweep_left > 0;
    endfunction

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (m_busy() || a == 5'd0) return 32'h0;
        if (bus.Write_Reg && !bus.Clr_Req && a == bus.W_Addr)
            return merge(mdl[a], bus.W_Data, bus.W_Be);
        return mdl[a];
    endfunction

    function automatic logic [31:0] exp_dbg(input logic [4:0] a);
        if (m_busy() || a == 5'd0) return 32'h0;
        return mdl[a];
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic compare();
        chk("busy", {31'b0, bus.Busy}, {31'b0, m_busy()});
        for (int p = 0; p < NREAD; p++)
            chk($sformatf("rd%0d", p), bus.R_Data[p*SIZE +: SIZE],
                exp_rd(bus.R_Addr[p*ADDR +: ADDR]));
        chk("dbg", bus.Dbg_Data, exp_dbg(bus.Dbg_Addr));
    endtask

    task automatic model_edge();
        if (!clr_n || bus.Clr_Req) begin
            sweep_left = NUMB;
            for (int a = 0; a < NUMB; a++) mdl[a] = 32'h0;
        end else if (sweep_left > 0) begin
            sweep_left--;
        end else if (bus.Write_Reg && bus.W_Addr != 5'd0) begin
            mdl[bus.W_Addr] = merge(mdl[bus.W_Addr], bus.W_Data, bus.W_Be);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        compare();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
        bus.Write_Reg = 1'b1;
        bus.W_Addr    = a;
        bus.W_Data    = d;
        bus.W_Be      = be;
        tick();
        bus.Write_Reg = 1'b0;
    endtask

    task automatic run_sweep(input string name);
        int n;
        n = 0;
        while (bus.Busy === 1'b1 && n < 100) begin
            tick();
            n++;
        end
        chk(name, n, 32);
    endtask

    task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] ad);
        bus.R_Addr   = {a1, a0};
        bus.Dbg_Addr = ad;
        #1;
    endtask

    initial begin
        for (int a = 0; a < NUMB; a++) mdl[a] = 32'h0;
        bus.Clr_Req   = 1'b0;
        bus.Write_Reg = 1'b0;
        bus.W_Addr    = '0;
        bus.W_Data    = '0;
        bus.W_Be      = '0;
        bus.R_Addr    = '0;
        bus.Dbg_Addr  = '0;

        // Reset held two cycles, then a full sweep.
        #1;
        chk("reset_busy", {31'b0, bus.Busy}, 32'd1);
        tick();
        tick();
        clr_n = 1'b1;
        run_sweep("reset_sweep_len");
        for (int a = 0; a < NUMB; a += 2) begin
            set_rd(5'(a), 5'(a + 1), 5'(a));
            chk("clr_p0", bus.R_Data[31:0], 32'h0);
            chk("clr_p1", bus.R_Data[63:32], 32'h0);
            tick();
        end

        // Byte-enable merge.
        wr(5'd5, 32'hDEADBEEF, 4'hF);
        set_rd(5'd5, 5'd5, 5'd5);
        wr(5'd5, 32'h00000011, 4'b0001);
        chk("be_merge", bus.R_Data[31:0], 32'hDEADBE11);
        chk("be_merge_dbg", bus.Dbg_Data, 32'hDEADBE11);
        wr(5'd5, 32'hFFFFFFFF, 4'h0);
        chk("be_none", bus.R_Data[63:32], 32'hDEADBE11);

        // Same-cycle bypass on port 1; debug tap shows the stored value.
        bus.Write_Reg = 1'b1;
        bus.W_Addr    = 5'd7;
        bus.W_Data    = 32'h12345678;
        bus.W_Be      = 4'hF;
        set_rd(5'd5, 5'd7, 5'd7);
        chk("bypass_p1", bus.R_Data[63:32], 32'h12345678);
        chk("bypass_dbg_old", bus.Dbg_Data, 32'h0);
        tick();
        bus.Write_Reg = 1'b0;
        #1;
        chk("after_wr_dbg", bus.Dbg_Data, 32'h12345678);

        // Register 0 is hardwired to zero.
        bus.Write_Reg = 1'b1;
        bus.W_Addr    = 5'd0;
        bus.W_Data    = 32'hFFFFFFFF;
        set_rd(5'd0, 5'd0, 5'd0);
        chk("r0_bypass", bus.R_Data[31:0], 32'h0);
        tick();
        bus.Write_Reg = 1'b0;
        #1;
        chk("r0_p0", bus.R_Data[31:0], 32'h0);
        chk("r0_p1", bus.R_Data[63:32], 32'h0);
        chk("r0_dbg", bus.Dbg_Data, 32'h0);

        // Idle clear request together with a write: write is dropped.
        bus.Write_Reg = 1'b1;
        bus.W_Addr    = 5'd3;
        bus.W_Data    = 32'hAAAA5555;
        bus.W_Be      = 4'hF;
        bus.Clr_Req   = 1'b1;
        set_rd(5'd3, 5'd7, 5'd3);
        chk("clrreq_no_bypass", bus.R_Data[31:0], 32'h0);
        tick();
        bus.Write_Reg = 1'b0;
        bus.Clr_Req   = 1'b0;
        run_sweep("idle_clrreq_len");
        set_rd(5'd3, 5'd7, 5'd5);
        chk("clrreq_a3", bus.R_Data[31:0], 32'h0);
        chk("clrreq_a7", bus.R_Data[63:32], 32'h0);
        chk("clrreq_a5", bus.Dbg_Data, 32'h0);

        // Clear request mid-sweep at cnt=10 restarts it.
        wr(5'd9, 32'hCAFEF00D, 4'hF);
        bus.Clr_Req = 1'b1;
        tick();
        bus.Clr_Req = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        bus.Clr_Req = 1'b1;
        tick();
        bus.Clr_Req = 1'b0;
        run_sweep("restart_len");
        set_rd(5'd9, 5'd9, 5'd9);
        chk("restart_a9", bus.R_Data[31:0], 32'h0);

        // Reset during a sweep at cnt=20.
        bus.Clr_Req = 1'b1;
        tick();
        bus.Clr_Req = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        clr_n = 1'b0;
        tick();
        clr_n = 1'b1;
        run_sweep("reset_mid_len");

        // Randomised traffic.
        for (int i = 0; i < 2000; i++) begin
            logic [4:0] a0, a1;
            bus.Write_Reg = 1'($urandom_range(0, 1));
            bus.W_Addr    = 5'($urandom_range(0, 31));
            bus.W_Data    = $urandom();
            bus.W_Be      = 4'($urandom_range(0, 15));
            bus.Clr_Req   = ($urandom_range(0, 299) == 0);
            a0 = ($urandom_range(0, 3) == 0) ? bus.W_Addr : 5'($urandom_range(0, 31));
            a1 = ($urandom_range(0, 3) == 0) ? bus.W_Addr : 5'($urandom_range(0, 31));
            if ($urandom_range(0, 9) == 0) a1 = a0;
            set_rd(a0, a1, 5'($urandom_range(0, 31)));
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
